// File: rtl/vc_fifo_bank_pkg.sv
// Shared definitions for the virtual-channel buffering stage and its arbiter:
// channel indices, default payload width and the idle data value.
package vc_fifo_bank_pkg;

    localparam int DATA_WIDTH_DEF = 4;
    localparam int NUM_VC         = 4;

    // Channel indices carried in the 2-bit channel field.
    typedef enum logic [1:0] {
        VCHANEL0 = 2'b00,
        VCHANEL1 = 2'b01,
        VCHANEL2 = 2'b10,
        VCHANEL3 = 2'b11
    } vc_id_e;

    // Value driven on a data output whose FIFO is empty or in reset.
    localparam logic DATA_IDLE_BIT = 1'b0;

    // Occupancy counter width: must hold 0..depth inclusive.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/vc_fifo_bank_if.sv
// Bus between the arbiter side (master) and the FIFO bank (slave):
// enqueue port, per-channel pops, head words, status flags and error flags.
interface vc_fifo_bank_if
    import vc_fifo_bank_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) ();

    logic                  enb;
    logic [DATA_WIDTH-1:0] in_data;
    logic [1:0]            in_vc;
    logic                  in_push;

    logic pop_vchanel0, pop_vchanel1, pop_vchanel2, pop_vchanel3;

    logic [DATA_WIDTH-1:0] out_vchanel0, out_vchanel1, out_vchanel2, out_vchanel3;
    logic empty_vchanel0, empty_vchanel1, empty_vchanel2, empty_vchanel3;
    logic full_vchanel0,  full_vchanel1,  full_vchanel2,  full_vchanel3;
    logic afull_vchanel0, afull_vchanel1, afull_vchanel2, afull_vchanel3;

    logic err_overflow;
    logic err_underflow;

    modport master (
        output enb, in_data, in_vc, in_push,
        output pop_vchanel0, pop_vchanel1, pop_vchanel2, pop_vchanel3,
        input  out_vchanel0, out_vchanel1, out_vchanel2, out_vchanel3,
        input  empty_vchanel0, empty_vchanel1, empty_vchanel2, empty_vchanel3,
        input  full_vchanel0, full_vchanel1, full_vchanel2, full_vchanel3,
        input  afull_vchanel0, afull_vchanel1, afull_vchanel2, afull_vchanel3,
        input  err_overflow, err_underflow
    );

    modport slave (
        input  enb, in_data, in_vc, in_push,
        input  pop_vchanel0, pop_vchanel1, pop_vchanel2, pop_vchanel3,
        output out_vchanel0, out_vchanel1, out_vchanel2, out_vchanel3,
        output empty_vchanel0, empty_vchanel1, empty_vchanel2, empty_vchanel3,
        output full_vchanel0, full_vchanel1, full_vchanel2, full_vchanel3,
        output afull_vchanel0, afull_vchanel1, afull_vchanel2, afull_vchanel3,
        output err_overflow, err_underflow
    );

endinterface

// File: rtl/vc_fifo.sv
// Single-channel show-ahead FIFO. Head word and flags come from registered
// state only, so the arbiter can decide on them in the cycle it pops.
// Optional macro VC_FIFO_ERR_EN adds overflow/underflow pulse outputs.
module vc_fifo
    import vc_fifo_bank_pkg::*;
#(
    parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
    parameter int DEPTH        = 4,
    parameter int AFULL_THRESH = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enb,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  empty,
    output logic                  full,
    output logic                  afull
`ifdef VC_FIFO_ERR_EN
    ,
    output logic                  ovf_pulse,
    output logic                  unf_pulse
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = cnt_width(DEPTH);
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AFULL_CNT = CNT_W'(AFULL_THRESH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wptr, rptr;
    logic [CNT_W-1:0]      count;
    logic                  push_acc, pop_acc;

    assign empty = (count == '0);
    assign full  = (count == FULL_CNT);
    assign afull = (count >= AFULL_CNT);

    // A pop on an empty channel is never accepted, even with a same-cycle push;
    // a push on a full channel is accepted only when the head leaves this cycle.
    assign pop_acc  = enb & pop & ~empty;
    assign push_acc = enb & push & (~full | pop_acc);

    assign rdata = empty ? {DATA_WIDTH{DATA_IDLE_BIT}} : mem[rptr];

`ifdef VC_FIFO_ERR_EN
    assign ovf_pulse = enb & push & full & ~pop_acc;
    assign unf_pulse = enb & pop & empty;
`endif

    // Storage write on an accepted push.
    // NOTE: the array has no reset; entries are only read once count covers them.
    always_ff @(posedge clk) begin
        if (push_acc) begin
            mem[wptr] <= wdata;
        end
    end

    // Pointer and occupancy update; pointers wrap naturally at DEPTH (power of two).
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push_acc) wptr <= wptr + PTR_W'(1);
            if (pop_acc)  rptr <= rptr + PTR_W'(1);
            case ({push_acc, pop_acc})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/vc_fifo_bank.sv
// Four virtual-channel FIFOs behind one enqueue port. The channel field steers
// each pushed word; the arbiter pops channels independently.
// Optional macro VC_FIFO_ERR_EN enables sticky err_overflow/err_underflow;
// without it both flags are tied low.
module vc_fifo_bank
    import vc_fifo_bank_pkg::*;
#(
    parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
    parameter int DEPTH        = 4,
    parameter int AFULL_THRESH = 3
) (
    input logic           clk,
    input logic           rst,
    vc_fifo_bank_if.slave bus
);

    logic [NUM_VC-1:0]     push_v;
    logic [NUM_VC-1:0]     pop_v;
    logic [NUM_VC-1:0]     empty_v, full_v, afull_v;
    logic [DATA_WIDTH-1:0] rdata_v [NUM_VC];
`ifdef VC_FIFO_ERR_EN
    logic [NUM_VC-1:0]     ovf_v, unf_v;
    logic                  err_ovf_q, err_unf_q;
`endif

    assign pop_v = {bus.pop_vchanel3, bus.pop_vchanel2, bus.pop_vchanel1, bus.pop_vchanel0};

    // Steer the single push request to the channel named by in_vc.
    // NOTE: default first so no path leaves push_v unassigned (no latch).
    always_comb begin
        push_v = '0;
        if (bus.in_push) begin
            case (vc_id_e'(bus.in_vc))
                VCHANEL0: push_v[0] = 1'b1;
                VCHANEL1: push_v[1] = 1'b1;
                VCHANEL2: push_v[2] = 1'b1;
                VCHANEL3: push_v[3] = 1'b1;
            endcase
        end
    end

    for (genvar n = 0; n < NUM_VC; n++) begin : g_vc
        vc_fifo #(
            .DATA_WIDTH  (DATA_WIDTH),
            .DEPTH       (DEPTH),
            .AFULL_THRESH(AFULL_THRESH)
        ) u_fifo (
            .clk  (clk),
            .rst  (rst),
            .enb  (bus.enb),
            .push (push_v[n]),
            .pop  (pop_v[n]),
            .wdata(bus.in_data),
            .rdata(rdata_v[n]),
            .empty(empty_v[n]),
            .full (full_v[n]),
            .afull(afull_v[n])
`ifdef VC_FIFO_ERR_EN
            ,
            .ovf_pulse(ovf_v[n]),
            .unf_pulse(unf_v[n])
`endif
        );
    end

    assign bus.out_vchanel0   = rdata_v[0];
    assign bus.out_vchanel1   = rdata_v[1];
    assign bus.out_vchanel2   = rdata_v[2];
    assign bus.out_vchanel3   = rdata_v[3];
    assign bus.empty_vchanel0 = empty_v[0];
    assign bus.empty_vchanel1 = empty_v[1];
    assign bus.empty_vchanel2 = empty_v[2];
    assign bus.empty_vchanel3 = empty_v[3];
    assign bus.full_vchanel0  = full_v[0];
    assign bus.full_vchanel1  = full_v[1];
    assign bus.full_vchanel2  = full_v[2];
    assign bus.full_vchanel3  = full_v[3];
    assign bus.afull_vchanel0 = afull_v[0];
    assign bus.afull_vchanel1 = afull_v[1];
    assign bus.afull_vchanel2 = afull_v[2];
    assign bus.afull_vchanel3 = afull_v[3];

`ifdef VC_FIFO_ERR_EN
    // Sticky error flags: any channel pulse sets them, only rst clears them.
    // Pulses are already gated by enb, so a frozen bank cannot set them.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_ovf_q <= 1'b0;
            err_unf_q <= 1'b0;
        end else begin
            if (|ovf_v) err_ovf_q <= 1'b1;
            if (|unf_v) err_unf_q <= 1'b1;
        end
    end

    assign bus.err_overflow  = err_ovf_q;
    assign bus.err_underflow = err_unf_q;
`else
    assign bus.err_overflow  = 1'b0;
    assign bus.err_underflow = 1'b0;
`endif

endmodule

// File: tb/tb_vc_fifo_bank.sv
// Directed bench for vc_fifo_bank. Expected error-flag values follow the
// VC_FIFO_ERR_EN build option.
module tb_vc_fifo_bank;

`ifdef VC_FIFO_ERR_EN
    localparam bit ERR_ON = 1'b1;
`else
    localparam bit ERR_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    int   vectors    = 0;
    int   miscompares = 0;

    vc_fifo_bank_if #(.DATA_WIDTH(4)) bus ();

    vc_fifo_bank #(
        .DATA_WIDTH  (4),
        .DEPTH       (4),
        .AFULL_THRESH(3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Status byte: {0, empty, full, afull, out[3:0]}.
    function automatic logic [7:0] st(input bit e, input bit f, input bit a, input logic [3:0] d);
        return {1'b0, e, f, a, d};
    endfunction

    task automatic get_st(input int n, output logic [7:0] s);
        case (n)
            0:       s = st(bus.empty_vchanel0, bus.full_vchanel0, bus.afull_vchanel0, bus.out_vchanel0);
            1:       s = st(bus.empty_vchanel1, bus.full_vchanel1, bus.afull_vchanel1, bus.out_vchanel1);
            2:       s = st(bus.empty_vchanel2, bus.full_vchanel2, bus.afull_vchanel2, bus.out_vchanel2);
            default: s = st(bus.empty_vchanel3, bus.full_vchanel3, bus.afull_vchanel3, bus.out_vchanel3);
        endcase
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
        end
    endtask

    task automatic chk_vc(input string tag, input int n, input logic [7:0] exp);
        logic [7:0] s;
        get_st(n, s);
        chk($sformatf("%s_vc%0d", tag, n), s, exp);
    endtask

    // One rising edge, then settle away from it before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pops(input logic [3:0] p);
        bus.pop_vchanel0 = p[0];
        bus.pop_vchanel1 = p[1];
        bus.pop_vchanel2 = p[2];
        bus.pop_vchanel3 = p[3];
    endtask

    task automatic push(input logic [1:0] vc, input logic [3:0] d);
        bus.in_push = 1'b1;
        bus.in_vc   = vc;
        bus.in_data = d;
    endtask

    initial begin
        // Reset for two cycles with a push request held high.
        rst = 1'b1;
        bus.enb = 1'b1;
        set_pops(4'b0000);
        push(2'd0, 4'hF);
        step();
        step();
        for (int n = 0; n < 4; n++) chk_vc("reset", n, st(1, 0, 0, 4'h0));
        chk("reset_err_ovf", {7'd0, bus.err_overflow}, 8'h00);
        chk("reset_err_unf", {7'd0, bus.err_underflow}, 8'h00);
        rst = 1'b0;
        bus.in_push = 1'b0;

        // VC2: push A,B,C; head stays A, afull at three words.
        push(2'd2, 4'hA); step(); chk_vc("push_a", 2, st(0, 0, 0, 4'hA));
        push(2'd2, 4'hB); step(); chk_vc("push_b", 2, st(0, 0, 0, 4'hA));
        push(2'd2, 4'hC); step(); chk_vc("push_c", 2, st(0, 0, 1, 4'hA));
        bus.in_push = 1'b0;
        chk_vc("untouched", 0, st(1, 0, 0, 4'h0));
        chk_vc("untouched", 1, st(1, 0, 0, 4'h0));
        chk_vc("untouched", 3, st(1, 0, 0, 4'h0));

        // VC2: three pops walk the head B, C, then empty.
        set_pops(4'b0100);
        step(); chk_vc("pop1", 2, st(0, 0, 0, 4'hB));
        step(); chk_vc("pop2", 2, st(0, 0, 0, 4'hC));
        step(); chk_vc("pop3", 2, st(1, 0, 0, 4'h0));
        set_pops(4'b0000);

        // VC1: fill to full, fifth push dropped.
        push(2'd1, 4'h1); step(); chk_vc("fill1", 1, st(0, 0, 0, 4'h1));
        push(2'd1, 4'h2); step(); chk_vc("fill2", 1, st(0, 0, 0, 4'h1));
        push(2'd1, 4'h3); step(); chk_vc("fill3", 1, st(0, 0, 1, 4'h1));
        push(2'd1, 4'h4); step(); chk_vc("fill4", 1, st(0, 1, 1, 4'h1));
        push(2'd1, 4'h5); step(); chk_vc("drop5", 1, st(0, 1, 1, 4'h1));
        bus.in_push = 1'b0;
        chk("err_ovf_set", {7'd0, bus.err_overflow}, {7'd0, ERR_ON});

        // VC1: drain returns 1,2,3,4 and nothing of the dropped word.
        set_pops(4'b0010);
        step(); chk_vc("drain1", 1, st(0, 0, 1, 4'h2));
        step(); chk_vc("drain2", 1, st(0, 0, 0, 4'h3));
        step(); chk_vc("drain3", 1, st(0, 0, 0, 4'h4));
        step(); chk_vc("drain4", 1, st(1, 0, 0, 4'h0));
        set_pops(4'b0000);

        // VC1: refill after both pointers wrapped.
        push(2'd1, 4'h6); step(); chk_vc("wrap6", 1, st(0, 0, 0, 4'h6));
        push(2'd1, 4'h7); step(); chk_vc("wrap7", 1, st(0, 0, 0, 4'h6));
        bus.in_push = 1'b0;
        set_pops(4'b0010);
        step(); chk_vc("wrap_pop", 1, st(0, 0, 0, 4'h7));
        set_pops(4'b0000);

        // VC0: full, then push 9 with a same-cycle pop.
        push(2'd0, 4'h1); step();
        push(2'd0, 4'h2); step();
        push(2'd0, 4'h3); step();
        push(2'd0, 4'h4); step();
        chk_vc("vc0_full", 0, st(0, 1, 1, 4'h1));
        push(2'd0, 4'h9);
        set_pops(4'b0001);
        step(); chk_vc("push_pop_full", 0, st(0, 1, 1, 4'h2));
        bus.in_push = 1'b0;
        step(); chk_vc("vc0_pop3", 0, st(0, 0, 1, 4'h3));
        step(); chk_vc("vc0_pop4", 0, st(0, 0, 0, 4'h4));
        step(); chk_vc("vc0_pop9", 0, st(0, 0, 0, 4'h9));
        step(); chk_vc("vc0_empty", 0, st(1, 0, 0, 4'h0));
        set_pops(4'b0000);
        chk("no_underflow_yet", {7'd0, bus.err_underflow}, 8'h00);

        // VC3: pop while empty with a same-cycle push of 7.
        push(2'd3, 4'h7);
        set_pops(4'b1000);
        step();
        bus.in_push = 1'b0;
        set_pops(4'b0000);
        chk_vc("empty_pop_push", 3, st(0, 0, 0, 4'h7));
        chk("err_unf_set", {7'd0, bus.err_underflow}, {7'd0, ERR_ON});

        // VC0 holds A,B; then five frozen cycles with every request active.
        push(2'd0, 4'hA); step();
        push(2'd0, 4'hB); step();
        bus.enb = 1'b0;
        push(2'd0, 4'h5);
        set_pops(4'b1111);
        for (int i = 0; i < 5; i++) begin
            step();
            chk_vc($sformatf("frozen%0d", i), 0, st(0, 0, 0, 4'hA));
        end
        chk_vc("frozen", 1, st(0, 0, 0, 4'h7));
        chk_vc("frozen", 2, st(1, 0, 0, 4'h0));
        chk_vc("frozen", 3, st(0, 0, 0, 4'h7));

        // Reset with enb still low discards everything.
        rst = 1'b1;
        step();
        for (int n = 0; n < 4; n++) chk_vc("mid_reset", n, st(1, 0, 0, 4'h0));
        chk("mid_reset_err_ovf", {7'd0, bus.err_overflow}, 8'h00);
        chk("mid_reset_err_unf", {7'd0, bus.err_underflow}, 8'h00);
        rst = 1'b0;
        bus.enb = 1'b1;
        set_pops(4'b0000);

        // First push after reset lands as a single-word head.
        push(2'd0, 4'hE); step();
        bus.in_push = 1'b0;
        chk_vc("post_reset", 0, st(0, 0, 0, 4'hE));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
